serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Serial-to-parallel receiver for the team's 4-bit shift-register datapath. It accepts a framed serial bit stream, one qualified bit per strobe, and assembles WIDTH-bit words in either bit order. Completed words are presented on a valid/ready parallel port backed by a one-entry holding register, so the next frame can be shifted in while the consumer stalls. It sits at the far end of a serial link driven by a parallel-load/shift transmitter.

## Interface
- WIDTH, 4, word width in bits (≥2)
- MSB_FIRST, 0, 0: first received bit lands in bit 0 (right-shift order); 1: first bit lands in bit WIDTH-1 (left-shift order)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- s_bit  input  1  serial data bit
- s_bit_valid  input  1  s_bit (and s_start) qualified this cycle
- s_start  input  1  with s_bit_valid: this bit is the first bit of a frame
- p_data  output  WIDTH  assembled word; stable while p_valid=1
- p_valid  output  1  holding register full
- p_ready  input  1  consumer accepts p_data when p_valid=1
- overrun  output  1  one-cycle pulse: completed word dropped
- frame_err  output  1  one-cycle pulse: partial frame aborted by new s_start

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: bits with s_bit_valid=1, s_start=0 are ignored. On s_bit_valid=1 and s_start=1: load the bit into the shift register, set cnt=1, go to SHIFT.
- SHIFT: each s_bit_valid=1 shifts in s_bit and sets cnt=cnt+1. Cycles without s_bit_valid hold state and count. There is no timeout.
- Shift rule: MSB_FIRST=0 gives sr <= {s_bit, sr[WIDTH-1:1]}. MSB_FIRST=1 gives sr <= {sr[WIDTH-2:0], s_bit}.
- Completion: the valid bit arriving with cnt==WIDTH-1 completes the word. The completed word (including that bit) goes to the holding register, and the FSM returns to IDLE. A new frame always requires a new s_start.
- s_start=1 with s_bit_valid=1 while in SHIFT: discard the partial word, pulse frame_err, and restart with this bit (cnt=1, stay in SHIFT). If this bit would also have completed the old word, restart takes priority and no word is produced.
- Holding register: loaded on completion when empty, or when full and p_ready=1 in the same cycle. p_valid stays 1 in that case.
- Completion while full and p_ready=0: the new word is dropped, overrun pulses, and the held word is unchanged.
- p_valid clears after a cycle with p_valid=1, p_ready=1 and no completion.
- cnt width is clog2(WIDTH)+1. It never wraps because it resets on completion and on restart.
- Reset: state=IDLE, cnt=0, sr=0, p_data=0, p_valid=0, overrun=0, frame_err=0. Reset mid-frame discards the partial word and the held word.

## Timing
- Completing bit sampled at edge N, so p_valid=1 and p_data are valid after edge N; a consumer sees them in cycle N+1.
- Minimum frame spacing is zero idle cycles: s_start may accompany the bit immediately after a completing bit.
- Throughput is one word per WIDTH valid bits while p_ready is held high.
- overrun and frame_err are registered and high for exactly one cycle, in the cycle after the triggering edge.
- p_data and p_valid depend only on registers, with no combinational path from p_ready.

## Structure
- Shared package serial_deser_pkg holds the state typedef (IDLE, SHIFT) and the count-width helper constant/function.
- Sub-module deser_out_buffer holds the one-entry holding register with valid/ready and overrun generation. The top level holds the FSM, counter and shift register.

## Test plan
- WIDTH=4, MSB_FIRST=0, p_ready=1: bits 1,0,1,1 with s_start on the first bit -> p_data=4'b1101 and one p_valid pulse. With MSB_FIRST=1 the same bits -> 4'b1011.
- Gaps between valid bits (s_bit_valid low 3 cycles between each) with the same frame -> identical word; p_valid rises exactly one cycle after the 4th valid bit.
- p_ready=0: send frame A (4'b0011), then frame B (4'b1100) -> p_data stays 4'b0011 and overrun pulses once. Raise p_ready -> A is accepted and p_valid drops.
- Back-to-back frames with p_ready asserted on the cycle B completes -> A handed off, p_data=B, p_valid stays 1, no overrun.
- s_start after 2 bits of a frame -> frame_err pulse, partial discarded; the next 4 bits yield only the new word. Bits without s_start in IDLE produce nothing.
- rst asserted after 2 bits and with a held word -> all outputs 0 next cycle; the following framed word assembles correctly.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types for the serial deserializer: the frame FSM state and the bit-counter width.
package serial_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_e;

  // The counter must hold WIDTH-1 and still be compared against it without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial ingress plus valid/ready parallel egress of the deserializer, with its status pulses.
interface serial_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             s_bit;
  logic             s_bit_valid;
  logic             s_start;
  logic [WIDTH-1:0] p_data;
  logic             p_valid;
  logic             p_ready;
  logic             overrun;
  logic             frame_err;

  modport master (
    output s_bit, s_bit_valid, s_start, p_ready,
    input  p_data, p_valid, overrun, frame_err
  );

  modport slave (
    input  s_bit, s_bit_valid, s_start, p_ready,
    output p_data, p_valid, overrun, frame_err
  );
endinterface

// File: rtl/deser_out_buffer.sv
// One-entry holding register: word visible the cycle after it is offered; no p_ready->p_valid path.
// Backpressure: a word offered while full and not being drained is dropped and overrun pulses.
module deser_out_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             load;

  always_comb begin
    load      = in_vld && (!valid_q || p_ready);
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      data_d  = in_dat;
      valid_d = 1'b1;
    end else if (valid_q && p_ready) begin
      valid_d = 1'b0;
    end
    if (in_vld && valid_q && !p_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_data  = data_q;
  assign p_valid = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver; a word appears on p_data the cycle after its last bit.
// A consumer stall holds one word while the next frame shifts in; a further word is dropped.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_deserializer_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] start_word;
  logic             done;

  always_comb begin
    if (MSB_FIRST) begin
      shifted    = {sr_q[WIDTH-2:0], bus.s_bit};
      start_word = {{(WIDTH-1){1'b0}}, bus.s_bit};
    end else begin
      shifted    = {bus.s_bit, sr_q[WIDTH-1:1]};
      start_word = {bus.s_bit, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_bit_valid && bus.s_start) begin
          sr_d    = start_word;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_bit_valid) begin
          // A fresh start wins even over the bit that would have completed the old word.
          if (bus.s_start) begin
            sr_d        = start_word;
            cnt_d       = CW'(1);
            frame_err_d = 1'b1;
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            sr_d    = shifted;
            cnt_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;

  deser_out_buffer #(
    .WIDTH (WIDTH)
  ) u_out_buffer (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (done),
    .in_dat  (shifted),
    .p_ready (bus.p_ready),
    .p_data  (bus.p_data),
    .p_valid (bus.p_valid),
    .overrun (bus.overrun)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: one LSB-first and one MSB-first deserializer fed the same serial stream.
module tb_serial_deserializer;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_deserializer_if #(.WIDTH(4)) bus0 ();
  serial_deserializer_if #(.WIDTH(4)) bus1 ();

  assign bus1.s_bit       = bus0.s_bit;
  assign bus1.s_bit_valid = bus0.s_bit_valid;
  assign bus1.s_start     = bus0.s_start;
  assign bus1.p_ready     = bus0.p_ready;

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic start);
    bus0.s_bit       = b;
    bus0.s_start     = start;
    bus0.s_bit_valid = 1'b1;
    tick();
    bus0.s_bit_valid = 1'b0;
    bus0.s_start     = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [3:0] d_lsb,
                         input logic [3:0] d_msb);
    chk({tag, "_vld_lsb"}, 32'(bus0.p_valid), 32'(vld));
    chk({tag, "_vld_msb"}, 32'(bus1.p_valid), 32'(vld));
    chk({tag, "_dat_lsb"}, 32'(bus0.p_data), 32'(d_lsb));
    chk({tag, "_dat_msb"}, 32'(bus1.p_data), 32'(d_msb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus0.s_bit       = 1'b0;
    bus0.s_bit_valid = 1'b0;
    bus0.s_start     = 1'b0;
    bus0.p_ready     = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 4'b0000, 4'b0000);
    chk("reset_ovr", 32'(bus0.overrun), 32'd0);
    chk("reset_ferr", 32'(bus0.frame_err), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame 1,0,1,1 with consumer ready.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("basic_pre_vld", 32'(bus0.p_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    chk_out("basic", 1'b1, 4'b1101, 4'b1011);
    tick();
    chk("basic_pulse_end", 32'(bus0.p_valid), 32'd0);

    // Same frame with three idle cycles between bits.
    send_bit(1'b1, 1'b1);
    repeat (3) tick();
    send_bit(1'b0, 1'b0);
    repeat (3) tick();
    send_bit(1'b1, 1'b0);
    repeat (3) tick();
    chk("gap_pre_vld", 32'(bus1.p_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    chk_out("gap", 1'b1, 4'b1101, 4'b1011);
    tick();
    chk("gap_pulse_end", 32'(bus1.p_valid), 32'd0);

    // Stalled consumer: A held, B dropped with one overrun pulse.
    bus0.p_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk_out("stallA", 1'b1, 4'b0011, 4'b1100);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("stall_no_ovr_early", 32'(bus0.overrun), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("stall_ovr_lsb", 32'(bus0.overrun), 32'd1);
    chk("stall_ovr_msb", 32'(bus1.overrun), 32'd1);
    chk_out("stallB", 1'b1, 4'b0011, 4'b1100);
    bus0.p_ready = 1'b1;
    tick();
    chk("stall_ovr_end", 32'(bus0.overrun), 32'd0);
    chk("stall_drain", 32'(bus0.p_valid), 32'd0);

    // Back-to-back frames; consumer takes A on the edge that completes B.
    bus0.p_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    bus0.p_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk_out("b2b", 1'b1, 4'b1100, 4'b0011);
    chk("b2b_no_ovr", 32'(bus0.overrun), 32'd0);
    tick();
    chk("b2b_drain", 32'(bus0.p_valid), 32'd0);

    // Restart after two bits, then restart on what would have been the completing bit.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("ferr1", 32'(bus0.frame_err), 32'd1);
    send_bit(1'b1, 1'b0);
    chk("ferr1_end", 32'(bus0.frame_err), 32'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("ferr2_lsb", 32'(bus0.frame_err), 32'd1);
    chk("ferr2_msb", 32'(bus1.frame_err), 32'd1);
    chk("ferr2_no_word", 32'(bus0.p_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk_out("ferr_word", 1'b1, 4'b0011, 4'b1100);
    tick();

    // Unframed bits in IDLE are ignored.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("idle_ignore_lsb", 32'(bus0.p_valid), 32'd0);
    chk("idle_ignore_msb", 32'(bus1.p_valid), 32'd0);

    // Reset with a held word and a partial frame in flight.
    bus0.p_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk_out("held", 1'b1, 4'b0101, 4'b1010);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 4'b0000, 4'b0000);
    chk("midrst_ovr", 32'(bus0.overrun), 32'd0);
    chk("midrst_ferr", 32'(bus0.frame_err), 32'd0);
    rst = 1'b0;
    bus0.p_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    chk("postrst_ferr", 32'(bus0.frame_err), 32'd0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk_out("postrst", 1'b1, 4'b0100, 4'b0010);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
